// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: sequencer states,
// bus transfer codes, NMI constants and interrupt-mode decode.
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_LATCH    = 3'd2,
        ST_PUSH_PC  = 3'd3,
        ST_PUSH_CCR = 3'd4,
        ST_PUSH_EXR = 3'd5,
        ST_VEC_RD   = 3'd6,
        ST_DONE     = 3'd7
    } seq_state_e;

    typedef enum logic [1:0] {
        OP_PUSH_PC  = 2'd0,
        OP_PUSH_CCR = 2'd1,
        OP_PUSH_EXR = 2'd2,
        OP_VEC_RD   = 2'd3
    } bus_op_e;

    typedef enum logic {
        MODE_0 = 1'b0,
        MODE_2 = 1'b1
    } int_mode_e;

    localparam logic [7:0] NMI_VECTOR = 8'h07;
    localparam logic [2:0] NMI_LEVEL  = 3'd7;

    // Mode 2 only for INTM1=1/INTM0=0; every other encoding behaves as mode 0.
    function automatic int_mode_e decode_mode(input logic intm1, input logic intm0);
        return (intm1 && !intm0) ? MODE_2 : MODE_0;
    endfunction

endpackage

// File: rtl/int_exception_sequencer.sv
// Exception entry sequencer: waits for an instruction boundary, latches the
// winning request, stacks PC/CCR(/EXR) over the bus, reads the vector and
// finally updates the CPU mask state.
module int_exception_sequencer
    import int_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       interrupt_request,
    input  logic [7:0] vector_number,
    input  logic [2:0] max_priority,
    input  logic       NMI_req,
    input  logic       INTM0,
    input  logic       INTM1,
    input  logic       inst_end,
    input  logic       bus_ack,
    output logic       bus_req,
    output logic [1:0] bus_op,
    output logic [9:0] vector_addr,
    output logic [7:0] acc_vector,
    output logic       exr_load,
    output logic [2:0] exr_new,
    output logic       i_bit_set,
    output logic       int_busy,
    output logic       seq_done
);

    seq_state_e state_q, state_d;
    logic [7:0] vector_q, vector_d;
    logic [2:0] level_q, level_d;
    int_mode_e  mode_q, mode_d;

    logic any_req;
    assign any_req = interrupt_request | NMI_req;

    // State and latched request context, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            vector_q <= '0;
            level_q  <= '0;
            mode_q   <= MODE_0;
        end else begin
            state_q  <= state_d;
            vector_q <= vector_d;
            level_q  <= level_d;
            mode_q   <= mode_d;
        end
    end

    // Next-state and context capture; requests are only sampled in LATCH.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        level_d  = level_q;
        mode_d   = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                // A request withdrawn before the boundary abandons the sequence.
                if (!any_req)      state_d = ST_IDLE;
                else if (inst_end) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                vector_d = NMI_req ? NMI_VECTOR : vector_number;
                level_d  = NMI_req ? NMI_LEVEL  : max_priority;
                mode_d   = decode_mode(INTM1, INTM0);
                state_d  = ST_PUSH_PC;
            end
            ST_PUSH_PC: begin
                if (bus_ack) state_d = ST_PUSH_CCR;
            end
            ST_PUSH_CCR: begin
                if (bus_ack) state_d = (mode_q == MODE_2) ? ST_PUSH_EXR : ST_VEC_RD;
            end
            ST_PUSH_EXR: begin
                if (bus_ack) state_d = ST_VEC_RD;
            end
            ST_VEC_RD: begin
                if (bus_ack) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        bus_req   = 1'b0;
        bus_op    = OP_PUSH_PC;
        exr_load  = 1'b0;
        exr_new   = '0;
        i_bit_set = 1'b0;
        int_busy  = 1'b0;
        seq_done  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_SYNC: begin
            end
            ST_LATCH: begin
                int_busy = 1'b1;
            end
            ST_PUSH_PC: begin
                int_busy = 1'b1;
                bus_req  = 1'b1;
                bus_op   = OP_PUSH_PC;
            end
            ST_PUSH_CCR: begin
                int_busy = 1'b1;
                bus_req  = 1'b1;
                bus_op   = OP_PUSH_CCR;
            end
            ST_PUSH_EXR: begin
                int_busy = 1'b1;
                bus_req  = 1'b1;
                bus_op   = OP_PUSH_EXR;
            end
            ST_VEC_RD: begin
                int_busy = 1'b1;
                bus_req  = 1'b1;
                bus_op   = OP_VEC_RD;
            end
            ST_DONE: begin
                int_busy  = 1'b1;
                seq_done  = 1'b1;
                i_bit_set = 1'b1;
                if (mode_q == MODE_2) begin
                    exr_load = 1'b1;
                    exr_new  = level_q;
                end
            end
            default: begin
            end
        endcase
    end

    assign acc_vector  = vector_q;
    assign vector_addr = {vector_q, 2'b00};

endmodule

// File: tb/tb_int_exception_sequencer.sv
// Scoreboard bench for int_exception_sequencer: expected bus transfers are
// queued when a request is posted and compared as the DUT issues them.
module tb_int_exception_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       interrupt_request;
    logic [7:0] vector_number;
    logic [2:0] max_priority;
    logic       NMI_req;
    logic       INTM0;
    logic       INTM1;
    logic       inst_end;
    logic       bus_ack;
    logic       bus_req;
    logic [1:0] bus_op;
    logic [9:0] vector_addr;
    logic [7:0] acc_vector;
    logic       exr_load;
    logic [2:0] exr_new;
    logic       i_bit_set;
    logic       int_busy;
    logic       seq_done;

    int_exception_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .interrupt_request (interrupt_request),
        .vector_number     (vector_number),
        .max_priority      (max_priority),
        .NMI_req           (NMI_req),
        .INTM0             (INTM0),
        .INTM1             (INTM1),
        .inst_end          (inst_end),
        .bus_ack           (bus_ack),
        .bus_req           (bus_req),
        .bus_op            (bus_op),
        .vector_addr       (vector_addr),
        .acc_vector        (acc_vector),
        .exr_load          (exr_load),
        .exr_new           (exr_new),
        .i_bit_set         (i_bit_set),
        .int_busy          (int_busy),
        .seq_done          (seq_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        int unsigned delay;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [7:0]  exp_acc;
    logic [2:0]  exp_lvl;
    logic        exp_mode2;
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Queue the transfers and final context a request should produce.
    task automatic expect_seq(input logic [7:0] vec, input logic [2:0] pri, input logic nmi,
                              input logic m1, input logic m0, input int unsigned ccr_delay);
        exp_mode2 = m1 && !m0;
        exp_acc   = nmi ? 8'h07 : vec;
        exp_lvl   = nmi ? 3'd7 : pri;
        exp_q.push_back('{op: 2'd0, delay: 0});
        exp_q.push_back('{op: 2'd1, delay: ccr_delay});
        if (exp_mode2) exp_q.push_back('{op: 2'd2, delay: 0});
        exp_q.push_back('{op: 2'd3, delay: 0});
    endtask

    // Bus responder plus completion checks; returns at the DONE cycle,
    // or on the first VEC_RD cycle when abort_vec is set (ack withheld).
    task automatic serve(input logic mid_nmi, input logic abort_vec);
        logic        started  = 1'b0;
        logic        in_xfer  = 1'b0;
        logic        finished = 1'b0;
        xfer_t       cur;
        int unsigned cyc    = 0;
        int unsigned n_ibit = 0;
        int unsigned n_exr  = 0;
        cur = '{op: 2'd0, delay: 0};
        for (int c = 0; c < 80 && !finished; c++) begin
            @(negedge clk);
            if (i_bit_set) n_ibit++;
            if (exr_load)  n_exr++;
            if (bus_req) begin
                if (!started) begin
                    started = 1'b1;
                    if (mid_nmi) NMI_req = 1'b1;
                    else begin
                        interrupt_request = 1'b0;
                        NMI_req = 1'b0;
                    end
                end
                if (!in_xfer && exp_q.size() == 0) begin
                    check_eq("extra_xfer", {30'd0, bus_op}, 32'hFFFF_FFFF);
                    bus_ack  = 1'b0;
                    finished = 1'b1;
                end else begin
                    if (!in_xfer) begin
                        cur     = exp_q.pop_front();
                        in_xfer = 1'b1;
                        cyc     = 0;
                        check_eq("op_start", {30'd0, bus_op}, {30'd0, cur.op});
                    end else begin
                        check_eq("op_hold", {30'd0, bus_op}, {30'd0, cur.op});
                    end
                    if (cur.op == 2'd3)
                        check_eq("vector_addr", {22'd0, vector_addr}, {22'd0, exp_acc, 2'b00});
                    if (abort_vec && cur.op == 2'd3) begin
                        bus_ack  = 1'b0;
                        finished = 1'b1;
                    end else if (cyc == cur.delay) begin
                        bus_ack = 1'b1;
                        in_xfer = 1'b0;
                    end else begin
                        bus_ack = 1'b0;
                        cyc++;
                    end
                end
            end else begin
                bus_ack = 1'b0;
                if (seq_done) begin
                    check_eq("ops_left",   exp_q.size(), 0);
                    check_eq("acc_vector", {24'd0, acc_vector}, {24'd0, exp_acc});
                    check_eq("int_busy",   {31'd0, int_busy}, 1);
                    check_eq("i_bit_set",  {31'd0, i_bit_set}, 1);
                    check_eq("ibit_count", n_ibit, 1);
                    check_eq("exr_load",   {31'd0, exr_load}, {31'd0, exp_mode2});
                    check_eq("exr_count",  n_exr, {31'd0, exp_mode2});
                    if (exp_mode2) check_eq("exr_new", {29'd0, exr_new}, {29'd0, exp_lvl});
                    finished = 1'b1;
                end
            end
        end
        if (!finished) check_eq("timeout", 0, 1);
        bus_ack = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq(tag, {bus_req, int_busy, i_bit_set, exr_load, seq_done, acc_vector, vector_addr},
                 '0);
    endtask

    initial begin
        rst_n = 1'b0;
        interrupt_request = 1'b0;
        vector_number = '0;
        max_priority = '0;
        NMI_req = 1'b0;
        INTM0 = 1'b0;
        INTM1 = 1'b0;
        inst_end = 1'b1;
        bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        // Mode 0, vector 0x40 priority 3: PC, CCR, VEC; addr 0x100.
        vector_number = 8'h40; max_priority = 3'd3;
        expect_seq(8'h40, 3'd3, 1'b0, 1'b0, 1'b0, 0);
        interrupt_request = 1'b1;
        serve(1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Mode 2, vector 0x21 priority 5: adds EXR push; exr_new=5, addr 0x084.
        INTM1 = 1'b1; INTM0 = 1'b0;
        vector_number = 8'h21; max_priority = 3'd5;
        expect_seq(8'h21, 3'd5, 1'b0, 1'b1, 1'b0, 0);
        interrupt_request = 1'b1;
        serve(1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // NMI alongside vector 0x40 in mode 2: vector 0x07, level 7.
        vector_number = 8'h40; max_priority = 3'd3;
        expect_seq(8'h40, 3'd3, 1'b1, 1'b1, 1'b0, 0);
        interrupt_request = 1'b1; NMI_req = 1'b1;
        serve(1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Request withdrawn in SYNC before the boundary: nothing happens,
        // even once inst_end returns.
        inst_end = 1'b0;
        interrupt_request = 1'b1;
        repeat (3) @(negedge clk);
        interrupt_request = 1'b0;
        inst_end = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("sync_drop_quiet", {27'd0, bus_req, int_busy, i_bit_set, exr_load, seq_done}, 0);
        end

        // INTM1=INTM0=1 behaves as mode 0; CCR ack delayed three cycles.
        INTM1 = 1'b1; INTM0 = 1'b1;
        vector_number = 8'h10; max_priority = 3'd6;
        expect_seq(8'h10, 3'd6, 1'b0, 1'b1, 1'b1, 3);
        interrupt_request = 1'b1;
        serve(1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset while VEC_RD waits for its ack, then a normal sequence.
        INTM1 = 1'b0; INTM0 = 1'b0;
        vector_number = 8'h55; max_priority = 3'd2;
        expect_seq(8'h55, 3'd2, 1'b0, 1'b0, 1'b0, 0);
        interrupt_request = 1'b1;
        serve(1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid_vec");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        INTM1 = 1'b1; INTM0 = 1'b0;
        vector_number = 8'hFF; max_priority = 3'd1;
        expect_seq(8'hFF, 3'd1, 1'b0, 1'b1, 1'b0, 0);
        interrupt_request = 1'b1;
        serve(1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // NMI raised mid-sequence is not latched; it starts a second sequence
        // immediately after DONE -> IDLE -> SYNC -> LATCH.
        vector_number = 8'h30; max_priority = 3'd4;
        expect_seq(8'h30, 3'd4, 1'b0, 1'b1, 1'b0, 0);
        interrupt_request = 1'b1;
        serve(1'b1, 1'b0);
        @(negedge clk);
        check_eq("b2b_idle", {31'd0, int_busy}, 0);
        @(negedge clk);
        check_eq("b2b_sync", {31'd0, int_busy}, 0);
        @(negedge clk);
        check_eq("b2b_latch", {31'd0, int_busy}, 1);
        expect_seq(8'h30, 3'd4, 1'b1, 1'b1, 1'b0, 0);
        serve(1'b0, 1'b0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
